// File: rtl/rv32_bus_arbiter.sv
// Two-master round-robin arbiter for the picorv32 native memory bus.
// A per-transaction watchdog answers stalled accesses with ERR_VALUE and logs a sticky error.
module rv32_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_VALUE      = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,
    input  logic        err_clear,
    output logic        err_flag,
    output logic        err_master,
    output logic [31:0] err_addr
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    localparam int unsigned   CNT_W    = (TIMEOUT_CYCLES > 32'd0) ? $clog2(TIMEOUT_CYCLES + 32'd1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);
    localparam bit            WDOG_EN  = (TIMEOUT_CYCLES != 32'd0);

    state_t             state_q, state_d;
    logic               grant_q, grant_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_flag_q, err_flag_d;
    logic               err_master_q, err_master_d;
    logic [31:0]        err_addr_q, err_addr_d;

    logic               gnt_valid_s;
    logic [31:0]        gnt_addr_s;
    logic               done_s;

    // Granted-master request mux.
    always_comb begin
        gnt_valid_s = grant_q ? m1_valid : m0_valid;
        gnt_addr_s  = grant_q ? m1_addr  : m0_addr;
    end

    // State and register update.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_q       <= 1'b1;
            cnt_q        <= '0;
            err_flag_q   <= 1'b0;
            err_master_q <= 1'b0;
            err_addr_q   <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            err_flag_q   <= err_flag_d;
            err_master_q <= err_master_d;
            err_addr_q   <= err_addr_d;
        end
    end

    // Next-state, arbitration, watchdog and error capture.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        err_flag_d   = err_clear ? 1'b0 : err_flag_q;
        err_master_d = err_master_q;
        err_addr_d   = err_addr_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (m0_valid && m1_valid) begin
                    grant_d = ~last_q;
                    state_d = ST_BUSY;
                end else if (m0_valid) begin
                    grant_d = 1'b0;
                    state_d = ST_BUSY;
                end else if (m1_valid) begin
                    grant_d = 1'b1;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // Completion beats the watchdog when both land on the same cycle.
                if (s_ready) begin
                    last_d  = grant_q;
                    state_d = ST_IDLE;
                end else if (!gnt_valid_s) begin
                    state_d = ST_IDLE;
                end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
                    state_d      = ST_ABORT;
                    err_addr_d   = gnt_addr_s;
                    err_master_d = grant_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ABORT: begin
                err_flag_d = 1'b1;
                last_d     = grant_q;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus-side outputs and master responses.
    always_comb begin
        done_s     = ((state_q == ST_BUSY) && s_ready) || (state_q == ST_ABORT);
        s_valid    = (state_q == ST_BUSY) && gnt_valid_s;
        s_addr     = gnt_addr_s;
        s_wdata    = grant_q ? m1_wdata : m0_wdata;
        s_wstrb    = grant_q ? m1_wstrb : m0_wstrb;
        m0_ready   = done_s && !grant_q;
        m1_ready   = done_s && grant_q;
        m0_rdata   = (state_q == ST_ABORT) ? ERR_VALUE : s_rdata;
        m1_rdata   = (state_q == ST_ABORT) ? ERR_VALUE : s_rdata;
        err_flag   = err_flag_q;
        err_master = err_master_q;
        err_addr   = err_addr_q;
    end

endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// Scoreboard bench for rv32_bus_arbiter: a TIMEOUT_CYCLES=4 instance for the main scenarios
// and a TIMEOUT_CYCLES=0 instance for the disabled-watchdog case.
module tb_rv32_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        m0_valid = 1'b0, m1_valid = 1'b0;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_addr = 32'h0, m1_addr = 32'h0, m0_wdata = 32'h0, m1_wdata = 32'h0;
    logic [3:0]  m0_wstrb = 4'h0, m1_wstrb = 4'h0;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, s_ready = 1'b0;
    logic [31:0] s_addr, s_wdata, s_rdata = 32'h0;
    logic [3:0]  s_wstrb;
    logic        err_clear = 1'b0, err_flag, err_master;
    logic [31:0] err_addr;

    logic        nt_m0_valid = 1'b0, nt_m0_ready, nt_m1_ready;
    logic [31:0] nt_m0_rdata, nt_m1_rdata, nt_s_addr, nt_s_wdata, nt_err_addr;
    logic        nt_s_valid, nt_s_ready = 1'b0, nt_err_flag, nt_err_master;
    logic [31:0] nt_s_rdata = 32'h0;
    logic [3:0]  nt_s_wstrb;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        master;
        logic [31:0] rdata;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    rv32_bus_arbiter #(.TIMEOUT_CYCLES(4), .ERR_VALUE(32'hDEAD_BEEF)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_rdata(s_rdata),
        .err_clear(err_clear), .err_flag(err_flag), .err_master(err_master), .err_addr(err_addr)
    );

    rv32_bus_arbiter #(.TIMEOUT_CYCLES(0), .ERR_VALUE(32'hDEAD_BEEF)) dut_nt (
        .clk(clk), .reset_n(reset_n),
        .m0_valid(nt_m0_valid), .m0_ready(nt_m0_ready), .m0_addr(32'h0000_0600),
        .m0_wdata(32'h0), .m0_wstrb(4'h0), .m0_rdata(nt_m0_rdata),
        .m1_valid(1'b0), .m1_ready(nt_m1_ready), .m1_addr(32'h0), .m1_wdata(32'h0),
        .m1_wstrb(4'h0), .m1_rdata(nt_m1_rdata),
        .s_valid(nt_s_valid), .s_ready(nt_s_ready), .s_addr(nt_s_addr), .s_wdata(nt_s_wdata),
        .s_wstrb(nt_s_wstrb), .s_rdata(nt_s_rdata),
        .err_clear(1'b0), .err_flag(nt_err_flag), .err_master(nt_err_master), .err_addr(nt_err_addr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every ready pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (m0_ready || m1_ready) begin
            check_eq("sb_one_ready", {31'd0, m0_ready && m1_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                check_eq("sb_unexpected", exp_q.size(), 32'd1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("sb_master", {31'd0, m1_ready}, {31'd0, e.master});
                check_eq("sb_rdata", m1_ready ? m1_rdata : m0_rdata, e.rdata);
            end
        end
    end

    initial begin
        int stall_bad;
        step();
        step();
        @(negedge clk);
        check_eq("rst_s_valid", {31'd0, s_valid}, 32'd0);
        check_eq("rst_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
        check_eq("rst_err_flag", {31'd0, err_flag}, 32'd0);
        check_eq("rst_err_master", {31'd0, err_master}, 32'd0);
        check_eq("rst_err_addr", err_addr, 32'd0);
        step();
        reset_n = 1'b1;

        // Single read with an immediately ready slave.
        step();
        m0_valid = 1'b1; m0_addr = 32'h0000_0100; m0_wstrb = 4'h0;
        s_ready = 1'b1; s_rdata = 32'h1234_5678;
        exp_q.push_back('{1'b0, 32'h1234_5678});
        @(negedge clk);
        check_eq("rd_idle_ready", {31'd0, m0_ready}, 32'd0);
        check_eq("rd_idle_s_valid", {31'd0, s_valid}, 32'd0);
        step();
        @(negedge clk);
        check_eq("rd_busy_ready", {31'd0, m0_ready}, 32'd1);
        check_eq("rd_busy_s_valid", {31'd0, s_valid}, 32'd1);
        check_eq("rd_s_addr", s_addr, 32'h0000_0100);
        step();
        m0_valid = 1'b0;
        @(negedge clk);
        check_eq("rd_err_flag", {31'd0, err_flag}, 32'd0);

        // Continuous contention: strict alternation starting with m0 (last=1 after reset would
        // pick m0; here m0 was just served, so m1 would win; reset again to start from m0).
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        m0_valid = 1'b1; m1_valid = 1'b1;
        m0_addr = 32'h0000_1000; m1_addr = 32'h1000_0000;
        s_rdata = 32'hC0DE_0001;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{1'b0, 32'hC0DE_0001});
            exp_q.push_back('{1'b1, 32'hC0DE_0001});
        end
        for (int k = 0; k < 12; k++) begin
            step();
            if (k == 11) begin
                m0_valid = 1'b0; m1_valid = 1'b0;
            end
            @(negedge clk);
            check_eq($sformatf("cont_m0_ready_%0d", k), {31'd0, m0_ready}, {31'd0, (k % 4) == 0});
            check_eq($sformatf("cont_m1_ready_%0d", k), {31'd0, m1_ready}, {31'd0, (k % 4) == 2});
        end

        // Timeout: m1 read to a silent slave.
        step();
        m1_valid = 1'b1; m1_addr = 32'h2000_0000; m1_wstrb = 4'h0; s_ready = 1'b0;
        exp_q.push_back('{1'b1, 32'hDEAD_BEEF});
        for (int k = 0; k < 4; k++) begin
            step();
            @(negedge clk);
            check_eq($sformatf("to_busy_s_valid_%0d", k), {31'd0, s_valid}, 32'd1);
            check_eq($sformatf("to_busy_ready_%0d", k), {31'd0, m1_ready}, 32'd0);
        end
        step();
        @(negedge clk);
        check_eq("to_abort_s_valid", {31'd0, s_valid}, 32'd0);
        check_eq("to_abort_ready", {31'd0, m1_ready}, 32'd1);
        step();
        m1_valid = 1'b0;
        @(negedge clk);
        check_eq("to_err_flag", {31'd0, err_flag}, 32'd1);
        check_eq("to_err_master", {31'd0, err_master}, 32'd1);
        check_eq("to_err_addr", err_addr, 32'h2000_0000);
        step();
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        @(negedge clk);
        check_eq("clr_err_flag", {31'd0, err_flag}, 32'd0);
        check_eq("clr_err_master_kept", {31'd0, err_master}, 32'd1);

        // Race: s_ready lands on the cycle the watchdog would fire.
        step();
        m0_valid = 1'b1; m0_addr = 32'h0000_0300; s_ready = 1'b0;
        exp_q.push_back('{1'b0, 32'h600D_0004});
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge clk);
            check_eq($sformatf("race_wait_ready_%0d", k), {31'd0, m0_ready}, 32'd0);
        end
        step();
        s_ready = 1'b1; s_rdata = 32'h600D_0004;
        @(negedge clk);
        check_eq("race_ready", {31'd0, m0_ready}, 32'd1);
        step();
        m0_valid = 1'b0; s_ready = 1'b0;
        @(negedge clk);
        check_eq("race_err_flag", {31'd0, err_flag}, 32'd0);
        check_eq("race_s_valid", {31'd0, s_valid}, 32'd0);

        // Abort coincident with err_clear: set wins.
        step();
        m0_valid = 1'b1; m0_addr = 32'h0000_0400; m0_wdata = 32'hFFFF_0000; m0_wstrb = 4'hF;
        exp_q.push_back('{1'b0, 32'hDEAD_BEEF});
        for (int k = 0; k < 4; k++) step();
        step();
        err_clear = 1'b1;
        @(negedge clk);
        check_eq("abclr_ready", {31'd0, m0_ready}, 32'd1);
        check_eq("abclr_s_valid", {31'd0, s_valid}, 32'd0);
        step();
        err_clear = 1'b0; m0_valid = 1'b0; m0_wstrb = 4'h0;
        @(negedge clk);
        check_eq("abclr_err_flag", {31'd0, err_flag}, 32'd1);
        check_eq("abclr_err_master", {31'd0, err_master}, 32'd0);
        check_eq("abclr_err_addr", err_addr, 32'h0000_0400);
        step();
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;

        // Reset mid-BUSY; m0 was served last, so only the reset makes m0 win the next tie.
        step();
        m0_valid = 1'b1; m0_addr = 32'h0000_0500; s_ready = 1'b0;
        step();
        @(negedge clk);
        check_eq("rstb_busy_s_valid", {31'd0, s_valid}, 32'd1);
        step();
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("rstb_no_ready", {31'd0, m0_ready}, 32'd0);
        step();
        reset_n = 1'b1; m0_valid = 1'b0;
        @(negedge clk);
        check_eq("rstb_s_valid", {31'd0, s_valid}, 32'd0);
        check_eq("rstb_ready", {31'd0, m0_ready}, 32'd0);
        step();
        m0_valid = 1'b1; m1_valid = 1'b1; s_ready = 1'b1; s_rdata = 32'h5EED_0000;
        exp_q.push_back('{1'b0, 32'h5EED_0000});
        step();
        @(negedge clk);
        check_eq("rstb_tie_m0", {31'd0, m0_ready}, 32'd1);
        check_eq("rstb_tie_m1", {31'd0, m1_ready}, 32'd0);
        step();
        m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;

        // Watchdog disabled: 1000-cycle stall completes normally.
        step();
        nt_m0_valid = 1'b1; nt_s_ready = 1'b0;
        step();
        stall_bad = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (nt_m0_ready || !nt_s_valid) stall_bad++;
            step();
        end
        check_eq("nt_stall_clean", stall_bad, 32'd0);
        nt_s_ready = 1'b1; nt_s_rdata = 32'h7A11_0000;
        @(negedge clk);
        check_eq("nt_ready", {31'd0, nt_m0_ready}, 32'd1);
        check_eq("nt_rdata", nt_m0_rdata, 32'h7A11_0000);
        step();
        nt_m0_valid = 1'b0; nt_s_ready = 1'b0;
        @(negedge clk);
        check_eq("nt_err_flag", {31'd0, nt_err_flag}, 32'd0);
        check_eq("nt_s_valid_idle", {31'd0, nt_s_valid}, 32'd0);

        step();
        check_eq("sb_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
